// File: rtl/cache_mem_responder.sv
// Memory-side responder for the 128-bit block cache interface: block storage,
// programmable completion latency, one-cycle mem_ready pulse, wrapping
// read/write counters and a sticky protocol-error flag.
module cache_mem_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [27:0]      mem_addr,
    input  logic [127:0]     mem_wdata,
    output logic [127:0]     mem_rdata,
    output logic             mem_ready,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count,
    output logic             proto_err
);

    localparam int unsigned DEPTH     = 2 ** DEPTH_LOG2;
    localparam int unsigned BLK_W     = 128;
    localparam int unsigned LAT_CNT_W = 8;
    // BUSY spends LATENCY-1 cycles; the counter runs LATENCY-2 down to 0
    localparam logic [LAT_CNT_W-1:0] CNT_LOAD =
        LAT_CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [LAT_CNT_W-1:0]  cnt;
    logic                  cmd_wr_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [BLK_W-1:0]      wdata_q;

    logic [BLK_W-1:0] mem_array [DEPTH];

    logic                  req;
    logic                  accept;
    logic                  enter_done;
    logic                  cur_wr;
    logic [DEPTH_LOG2-1:0] cur_idx;
    logic [BLK_W-1:0]      cur_wdata;

    // Address bits above the array index are intentionally ignored
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_addr[27:DEPTH_LOG2];

    assign req = mem_read | mem_write;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req) begin
                    next_state = (LATENCY == 1) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Transaction decode; with LATENCY=1 DONE is entered on the accept edge,
    // so the live request is used there instead of the latched copy
    always_comb begin
        accept     = 1'b0;
        enter_done = 1'b0;
        cur_wr     = cmd_wr_q;
        cur_idx    = idx_q;
        cur_wdata  = wdata_q;
        if (state == IDLE) begin
            accept    = req;
            cur_wr    = mem_write;
            cur_idx   = mem_addr[DEPTH_LOG2-1:0];
            cur_wdata = mem_wdata;
        end
        if ((next_state == DONE) && (state != DONE)) begin
            enter_done = 1'b1;
        end
    end

    // Request latch and latency counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            cmd_wr_q <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
        end else if (accept) begin
            cnt      <= CNT_LOAD;
            cmd_wr_q <= mem_write;
            idx_q    <= mem_addr[DEPTH_LOG2-1:0];
            wdata_q  <= mem_wdata;
        end else if ((state == BUSY) && (cnt != '0)) begin
            cnt <= cnt - LAT_CNT_W'(1);
        end
    end

    // Completion outputs, counters and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            rd_count  <= '0;
            wr_count  <= '0;
            proto_err <= 1'b0;
        end else begin
            mem_ready <= enter_done;
            if (enter_done) begin
                if (cur_wr) begin
                    wr_count <= wr_count + CNT_W'(1);
                end else begin
                    rd_count  <= rd_count + CNT_W'(1);
                    mem_rdata <= mem_array[cur_idx];
                end
            end
            if (accept && mem_read && mem_write) begin
                proto_err <= 1'b1;
            end
        end
    end

    // Block storage, unreset; a write commits only on the edge entering DONE
    always_ff @(posedge clk) begin
        if (enter_done && cur_wr && !rst) begin
            mem_array[cur_idx] <= cur_wdata;
        end
    end

endmodule
